// File: rtl/datapath_run_ctrl.sv
// Run/step/halt sequencer for the single-cycle datapath: gates PC advance and RF write.
// Optional build macro AUTO_START_EN: start running on the first edge after reset release.
module datapath_run_ctrl #(
   parameter int         CYCLE_W      = 16,
   parameter logic [5:0] HALT_OPCODE  = 6'b111111,
   parameter logic [5:0] RTYPE_OPCODE = 6'b000000
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               Start,
   input  logic               Step_Req,
   input  logic               Halt_Req,
   input  logic [5:0]         Opcode,
   input  logic [CYCLE_W-1:0] Cycle_Limit,
   output logic               PC_Enable,
   output logic               RF_Write_Enable_Flag,
   output logic               Step_Ack,
   output logic               Halted,
   output logic [1:0]         State,
   output logic [CYCLE_W-1:0] Cycle_Count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_HALT = 2'b11
   } state_t;

   localparam logic [CYCLE_W-1:0] COUNT_MAX = {CYCLE_W{1'b1}};
   localparam logic [CYCLE_W-1:0] COUNT_ONE = {{(CYCLE_W-1){1'b0}}, 1'b1};

   state_t             state_reg, state_next;
   logic [CYCLE_W-1:0] cycle_count_reg, cycle_count_next;
   logic               step_prev_reg;
   logic               exec;
   logic               limit_hit;
   logic               step_rise;
   logic               step_ack_next;
   logic               auto_go;

`ifdef AUTO_START_EN
   // Armed only by reset, so a later return to IDLE does not restart the run.
   logic auto_arm_reg;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         auto_arm_reg <= 1'b1;
      end else begin
         auto_arm_reg <= 1'b0;
      end
   end

   assign auto_go = auto_arm_reg;
`else
   assign auto_go = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_reg       <= ST_IDLE;
         cycle_count_reg <= '0;
         step_prev_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cycle_count_reg <= cycle_count_next;
         step_prev_reg   <= Step_Req;
      end
   end

   always_comb begin
      limit_hit = (Cycle_Limit != '0) && (cycle_count_reg == Cycle_Limit);
      exec      = ((state_reg == ST_RUN) || (state_reg == ST_STEP)) && !Halt_Req
                  && (Opcode != HALT_OPCODE) && !limit_hit;
      step_rise = Step_Req && !step_prev_reg;

      state_next    = state_reg;
      step_ack_next = 1'b0;
      if (exec && (cycle_count_reg != COUNT_MAX)) begin
         cycle_count_next = cycle_count_reg + COUNT_ONE;
      end else begin
         cycle_count_next = cycle_count_reg;
      end

      case (state_reg)
         ST_IDLE: begin
            if (Start || auto_go) begin
               state_next       = ST_RUN;
               cycle_count_next = '0;
            end else if (step_rise) begin
               state_next = ST_STEP;
            end
         end
         ST_RUN: begin
            if (!exec) begin
               state_next = ST_HALT;
            end
         end
         ST_STEP: begin
            step_ack_next = exec;
            state_next    = exec ? ST_IDLE : ST_HALT;
         end
         ST_HALT: begin
            if (Start) begin
               state_next       = ST_RUN;
               cycle_count_next = '0;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Everything is held at zero while reset is asserted, including a mid-run PC advance.
   assign PC_Enable            = RST && exec;
   assign RF_Write_Enable_Flag = RST && exec && (Opcode == RTYPE_OPCODE);
   assign Step_Ack             = RST && step_ack_next;
   assign Halted               = RST && (state_reg == ST_HALT);
   assign State                = RST ? state_reg : ST_IDLE;
   assign Cycle_Count          = RST ? cycle_count_reg : '0;

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Bench for datapath_run_ctrl: per-cycle behavioural model comparison plus directed literal checks.
module tb_datapath_run_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        Start;
   logic        Step_Req;
   logic        Halt_Req;
   logic [5:0]  Opcode;
   logic [15:0] Cycle_Limit;
   logic        PC_Enable;
   logic        RF_Write_Enable_Flag;
   logic        Step_Ack;
   logic        Halted;
   logic [1:0]  State;
   logic [15:0] Cycle_Count;

   int errors = 0;
   int checks = 0;
   int pc_cnt = 0;
   int rf_cnt = 0;
   int ack_cnt = 0;

   // Model state: mode uses the output encoding 0 idle, 1 run, 2 step, 3 halt.
   int m_mode = 0;
   int m_cnt  = 0;
   bit m_prev = 1'b0;
   bit m_arm  = 1'b0;

   always #5 CLK = ~CLK;

   datapath_run_ctrl dut (
      .CLK                  (CLK),
      .RST                  (RST),
      .Start                (Start),
      .Step_Req             (Step_Req),
      .Halt_Req             (Halt_Req),
      .Opcode               (Opcode),
      .Cycle_Limit          (Cycle_Limit),
      .PC_Enable            (PC_Enable),
      .RF_Write_Enable_Flag (RF_Write_Enable_Flag),
      .Step_Ack             (Step_Ack),
      .Halted               (Halted),
      .State                (State),
      .Cycle_Count          (Cycle_Count)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit m_exec();
      return ((m_mode == 1) || (m_mode == 2)) && !Halt_Req && (Opcode != 6'h3F)
             && !((Cycle_Limit != 0) && (m_cnt == int'(Cycle_Limit)));
   endfunction

   always @(posedge CLK) begin : model
      bit e;
      int nm;
      int nc;
      e  = m_exec();
      nm = m_mode;
      nc = m_cnt;
      if (!RST) begin
         nm = 0;
         nc = 0;
         m_prev <= 1'b0;
`ifdef AUTO_START_EN
         m_arm <= 1'b1;
`endif
      end else begin
         if (e && (nc < 65535)) nc = nc + 1;
         if (m_mode == 0) begin
            if (Start || m_arm) begin
               nm = 1;
               nc = 0;
            end else if (Step_Req && !m_prev) begin
               nm = 2;
            end
         end else if (m_mode == 1) begin
            if (!e) nm = 3;
         end else if (m_mode == 2) begin
            nm = e ? 0 : 3;
         end else if (Start) begin
            nm = 1;
            nc = 0;
         end
         m_prev <= Step_Req;
         m_arm  <= 1'b0;
      end
      m_mode <= nm;
      m_cnt  <= nc;
   end

   always @(negedge CLK) begin : compare
      bit e;
      e = RST && m_exec();
      chk("pc_enable",   PC_Enable, e);
      chk("rf_write",    RF_Write_Enable_Flag, e && (Opcode == 6'h00));
      chk("step_ack",    Step_Ack, e && (m_mode == 2));
      chk("halted",      Halted, RST && (m_mode == 3));
      chk("state",       State, RST ? m_mode : 0);
      chk("cycle_count", Cycle_Count, RST ? m_cnt : 0);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge CLK);
         pc_cnt  += int'(PC_Enable);
         rf_cnt  += int'(RF_Write_Enable_Flag);
         ack_cnt += int'(Step_Ack);
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic clr();
      pc_cnt  = 0;
      rf_cnt  = 0;
      ack_cnt = 0;
   endtask

   initial begin
      RST = 1'b0; Start = 1'b1; Step_Req = 1'b0; Halt_Req = 1'b0;
      Opcode = 6'h00; Cycle_Limit = 16'd0;

      // T1 reset with Start held
      tick(3);
      chk("t1_state", State, 0);
      chk("t1_pc", PC_Enable, 0);
      chk("t1_rf", RF_Write_Enable_Flag, 0);
      chk("t1_count", Cycle_Count, 0);
      RST = 1'b1; Start = 1'b0;
`ifdef AUTO_START_EN
      tick(1);
      chk("t6_state", State, 1);
      chk("t6_pc", PC_Enable, 1);
      Halt_Req = 1'b1;
      tick(1);
      Halt_Req = 1'b0;
`else
      tick(2);
      chk("idle_hold", State, 0);
`endif

      // T2 run with limit 5
      Cycle_Limit = 16'd5; Start = 1'b1;
      tick(1);
      Start = 1'b0; clr();
      tick(8);
      chk("t2_pc_pulses", pc_cnt, 5);
      chk("t2_rf_pulses", rf_cnt, 5);
      chk("t2_count", Cycle_Count, 5);
      chk("t2_state", State, 3);
      chk("t2_halted", Halted, 1);

      // T3 halt opcode on 4th cycle, then resume onto the same opcode
      Cycle_Limit = 16'd0; Start = 1'b1;
      tick(1);
      Start = 1'b0; clr();
      tick(3);
      Opcode = 6'h3F;
      tick(2);
      chk("t3_pc_pulses", pc_cnt, 3);
      chk("t3_count", Cycle_Count, 3);
      chk("t3_state", State, 3);
      Start = 1'b1;
      tick(1);
      Start = 1'b0;
      chk("t3_resume_state", State, 1);
      chk("t3_resume_count", Cycle_Count, 0);
      tick(1);
      chk("t3_rehalt_state", State, 3);
      chk("t3_rehalt_pc", pc_cnt, 3);

      // T5 external halt after 7 instructions, then restart
      Opcode = 6'h00; Start = 1'b1;
      tick(1);
      Start = 1'b0; clr();
      tick(7);
      chk("t5_count_pre", Cycle_Count, 7);
      Halt_Req = 1'b1;
      tick(1);
      chk("t5_pc_pulses", pc_cnt, 7);
      chk("t5_count", Cycle_Count, 7);
      chk("t5_state", State, 3);
      Halt_Req = 1'b0; Start = 1'b1;
      tick(1);
      Start = 1'b0;
      chk("t5_restart_state", State, 1);
      chk("t5_restart_count", Cycle_Count, 0);

      // reset while running
      clr(); RST = 1'b0;
      tick(1);
      chk("rst_mid_pc", pc_cnt, 0);
      chk("rst_mid_state", State, 0);
      RST = 1'b1;

`ifndef AUTO_START_EN
      // T4 single step with held request, non-R-type opcode
      Opcode = 6'h23; Step_Req = 1'b1; clr();
      tick(4);
      Step_Req = 1'b0;
      tick(1);
      chk("t4_acks", ack_cnt, 1);
      chk("t4_pc_pulses", pc_cnt, 1);
      chk("t4_rf_pulses", rf_cnt, 0);
      chk("t4_state", State, 0);
      chk("t4_count", Cycle_Count, 1);

      // step onto a halt opcode
      Opcode = 6'h3F; Step_Req = 1'b1; clr();
      tick(2);
      Step_Req = 1'b0;
      chk("step_halt_ack", ack_cnt, 0);
      chk("step_halt_state", State, 3);
      chk("step_halt_count", Cycle_Count, 1);

      // Start and Halt_Req together in IDLE
      RST = 1'b0;
      tick(1);
      RST = 1'b1; Opcode = 6'h00; Start = 1'b1; Halt_Req = 1'b1;
      tick(1);
      Start = 1'b0;
      chk("simul_run", State, 1);
      tick(1);
      chk("simul_halt", State, 3);
      chk("simul_count", Cycle_Count, 0);
      Halt_Req = 1'b0;
`endif

      // saturation with unlimited run
      Opcode = 6'h00; Cycle_Limit = 16'd0; Start = 1'b1;
      tick(1);
      Start = 1'b0;
      tick(65540);
      chk("sat_count", Cycle_Count, 65535);
      chk("sat_state", State, 1);
      Halt_Req = 1'b1;
      tick(1);
      chk("sat_halt_state", State, 3);
      chk("sat_halt_count", Cycle_Count, 65535);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
